viterbi_channel_err_inj: RTL and testbench
==========================================

// Module: viterbi_channel_err_inj
// PURPOSE
// - Parametrised channel impairment stage between the convolutional encoder and the Viterbi decoder.
// - Flips selected bits of SYM_W-bit code symbols in one of four modes:
//   - pass-through
//   - periodic (generalises the fixed 1-in-8 injection)
//   - burst
//   - LFSR-random
// - Counts symbols and injected errors over a programmable measurement window for BER checks.
// PARAMETERS
// - SYM_W     2        symbol width (code rate 1/SYM_W)
// - PERIOD_W  8        width of period_i / thresh_i and of the phase counter
// - CNT_W     16       width of the symbol and injection counters
// - LFSR_SEED 16'hACE1 reset/clear seed of the 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1)
// PORTS
// - clk          in   1         rising-edge clock
// - rst          in   1         asynchronous, active-low reset
// - sym_valid_i  in   1         sym_i valid this cycle
// - sym_i        in   SYM_W     encoder output symbol
// - mode_i       in   2         00 pass, 01 periodic, 10 burst, 11 random
// - period_i     in   PERIOD_W  trigger period in valid symbols; 0 = never trigger
// - burst_len_i  in   4         symbols per burst; 0 treated as 1
// - thresh_i     in   PERIOD_W  random mode: inject when lfsr[PERIOD_W-1:0] < thresh_i
// - bit_mask_i   in   SYM_W     bits XORed into a symbol when it is injected
// - win_len_i    in   CNT_W     measurement window in valid symbols; 0 = unbounded
// - clr_i        in   1         synchronous clear of counters/state
// - sym_valid_o  out  1         registered copy of sym_valid_i
// - sym_o        out  SYM_W     sym_i ^ (inject ? bit_mask_i : 0), registered
// - err_flag_o   out  1         high with sym_o when that symbol was injected
// - sym_cnt_o    out  CNT_W     valid symbols counted in the window
// - inj_cnt_o    out  CNT_W     injected symbols counted in the window
// - win_done_o   out  1         sticky: window complete
// BEHAVIOUR
// - Reset (rst=0, async): all outputs 0, phase=0, burst_rem=0, lfsr=LFSR_SEED.
// - Latency: exactly 1 clk; sym_o/err_flag_o/sym_valid_o update every cycle. With sym_valid_i=0, sym_o=sym_i and err_flag_o=0.
// - Internal state advances only on valid cycles: phase, burst_rem, LFSR.
// - phase: counts 0..period_i-1, wraps to 0; trigger = (phase==period_i-1).
//   - period_i=1: trigger on every symbol.
//   - period_i=0: phase held at 0, no trigger.
// - Per-mode inject decision:
//   - 00: never.
//   - 01: inject = trigger.
//   - 10: on trigger, burst_rem loads max(burst_len_i,1)-1 and this symbol is injected; inject also while burst_rem>0, decrementing. A trigger during a burst reloads it.
//   - 11: inject = (lfsr[PERIOD_W-1:0] < thresh_i), using the pre-advance LFSR value; thresh_i=0 never injects.
// - Mode/period changes take effect on the next valid symbol. phase is not reset on a mode change. burst_rem is cleared when mode_i!=10.
// - Window counters:
//   - On each valid symbol while !win_done_o: sym_cnt_o+=1 and inj_cnt_o+=inject.
//   - win_done_o sets in the cycle sym_cnt_o reaches win_len_i (win_len_i!=0) and freezes both counters.
//   - Injection still occurs after win_done_o.
//   - Counters saturate at all-ones.
// - clr_i=1: counters, win_done_o, phase, burst_rem -> 0 and lfsr -> LFSR_SEED on the next edge. A valid symbol in that cycle passes unmodified (err_flag_o=0) and is not counted. clr_i has priority over all updates.
// - bit_mask_i=0 with inject=1: sym_o unchanged, but err_flag_o=1 and the symbol is counted.
// CONFIGURATION
// - VITERBI_ERR_INJ_BURST_EN defined: burst mode (10) and burst_len_i are implemented as above.
// - Undefined: no burst_rem register; mode 10 behaves exactly as mode 01; burst_len_i is ignored (port kept).
// TESTING
// - Reset mid-stream (rst low 1 cycle during mode 01) -> all outputs 0 within same cycle; phase restarts at 0.
// - mode 01, period=8, mask=2'b10, 256 valid symbols, win=256 -> symbols 7,15,...,255 flipped on bit1; inj_cnt=32, sym_cnt=256, win_done=1.
// - mode 10 (BURST_EN), period=16, burst_len=3, 64 symbols -> symbols 15-17, 31-33, 47-49 injected (63 starts a burst); inj_cnt=10.
// - mode 11, thresh=0 -> inj_cnt=0; thresh=8'hFF, PERIOD_W=8 -> 255/256 symbols injected over LFSR sequence from seed.
// - clr_i coincident with a trigger symbol -> that symbol unmodified, err_flag_o=0, counters 0 next cycle; period=0 in mode 01 -> never injects.
// - Counter saturation: CNT_W=4, win=0, 20 valid symbols, period=1 -> sym_cnt=inj_cnt=15, win_done=0.

Source files
------------

// File: rtl/viterbi_channel_err_inj.sv
// viterbi_channel_err_inj: flips code-symbol bits (pass/periodic/burst/LFSR-random) and counts BER window stats.
// Burst mode 10 exists only with VITERBI_ERR_INJ_BURST_EN defined; otherwise mode 10 acts as periodic.
module viterbi_channel_err_inj #(
    parameter int          SYM_W     = 2,
    parameter int          PERIOD_W  = 8,
    parameter int          CNT_W     = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sym_valid_i,
    input  logic [SYM_W-1:0]    sym_i,
    input  logic [1:0]          mode_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic [3:0]          burst_len_i,
    input  logic [PERIOD_W-1:0] thresh_i,
    input  logic [SYM_W-1:0]    bit_mask_i,
    input  logic [CNT_W-1:0]    win_len_i,
    input  logic                clr_i,
    output logic                sym_valid_o,
    output logic [SYM_W-1:0]    sym_o,
    output logic                err_flag_o,
    output logic [CNT_W-1:0]    sym_cnt_o,
    output logic [CNT_W-1:0]    inj_cnt_o,
    output logic                win_done_o
);
    logic [PERIOD_W-1:0] r_phase;
    logic [15:0]         r_lfsr;
    logic [CNT_W-1:0]    r_sym_cnt, r_inj_cnt;
    logic [SYM_W-1:0]    r_sym;
    logic                r_valid, r_err, r_win_done;
    logic                w_adv, w_trig, w_burst, w_inj;
    logic [15:0]         w_lfsr_nxt;
    logic [CNT_W-1:0]    w_sym_cnt_nxt;

    assign w_adv         = sym_valid_i && !clr_i;
    assign w_trig        = (period_i != '0) && (r_phase == period_i - 1'b1);
    assign w_lfsr_nxt    = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    assign w_sym_cnt_nxt = (&r_sym_cnt) ? r_sym_cnt : r_sym_cnt + 1'b1;

`ifdef VITERBI_ERR_INJ_BURST_EN
    logic [3:0] r_burst_rem;
    assign w_burst = w_trig || (r_burst_rem != 4'd0);
    // A trigger mid-burst reloads the remaining length
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_burst_rem <= 4'd0;
        else if (clr_i)
            r_burst_rem <= 4'd0;
        else if (sym_valid_i)
            r_burst_rem <= (mode_i != 2'b10) ? 4'd0 :
                           w_trig ? ((burst_len_i == 4'd0) ? 4'd0 : burst_len_i - 4'd1) :
                           (r_burst_rem != 4'd0) ? r_burst_rem - 4'd1 : 4'd0;
    end
`else
    assign w_burst = w_trig;
`endif

    assign w_inj = w_adv && ((mode_i == 2'b01) ? w_trig :
                             (mode_i == 2'b10) ? w_burst :
                             (mode_i == 2'b11) ? (r_lfsr[PERIOD_W-1:0] < thresh_i) : 1'b0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid    <= 1'b0;
            r_sym      <= '0;
            r_err      <= 1'b0;
            r_phase    <= '0;
            r_lfsr     <= LFSR_SEED;
            r_sym_cnt  <= '0;
            r_inj_cnt  <= '0;
            r_win_done <= 1'b0;
        end else begin
            r_valid <= sym_valid_i;
            r_sym   <= sym_i ^ (w_inj ? bit_mask_i : '0);
            r_err   <= w_inj;
            if (clr_i) begin
                r_phase    <= '0;
                r_lfsr     <= LFSR_SEED;
                r_sym_cnt  <= '0;
                r_inj_cnt  <= '0;
                r_win_done <= 1'b0;
            end else if (sym_valid_i) begin
                r_phase <= (w_trig || period_i == '0) ? '0 : r_phase + 1'b1;
                r_lfsr  <= w_lfsr_nxt;
                // Counters freeze once the window completes; injection continues
                if (!r_win_done) begin
                    r_sym_cnt  <= w_sym_cnt_nxt;
                    r_inj_cnt  <= (w_inj && !(&r_inj_cnt)) ? r_inj_cnt + 1'b1 : r_inj_cnt;
                    r_win_done <= (win_len_i != '0) && (w_sym_cnt_nxt == win_len_i);
                end
            end
        end
    end

    assign sym_valid_o = r_valid;
    assign sym_o       = r_sym;
    assign err_flag_o  = r_err;
    assign sym_cnt_o   = r_sym_cnt;
    assign inj_cnt_o   = r_inj_cnt;
    assign win_done_o  = r_win_done;
endmodule

// File: tb/tb_viterbi_channel_err_inj.sv
// tb_viterbi_channel_err_inj: random stimulus against a symbol-index based model of the error injector.
// Honours VITERBI_ERR_INJ_BURST_EN the same way the design does.
module tb_viterbi_channel_err_inj;
`ifdef VITERBI_ERR_INJ_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif
    logic        clk = 1'b0, rst = 1'b0, vi = 1'b0, clr = 1'b0;
    logic [1:0]  sym = '0, mode = '0, mask = '0;
    logic [7:0]  per = '0, th = '0;
    logic [3:0]  bl = '0;
    logic [15:0] win = '0;
    logic        vo, err, wd, vo4, err4, wd4;
    logic [1:0]  so, so4;
    logic [15:0] sc, ic;
    logic [3:0]  sc4, ic4;
    int          nchk = 0, nerr = 0;

    always #5 clk = ~clk;

    viterbi_channel_err_inj dut (
        .clk(clk), .rst(rst), .sym_valid_i(vi), .sym_i(sym), .mode_i(mode), .period_i(per),
        .burst_len_i(bl), .thresh_i(th), .bit_mask_i(mask), .win_len_i(win), .clr_i(clr),
        .sym_valid_o(vo), .sym_o(so), .err_flag_o(err), .sym_cnt_o(sc), .inj_cnt_o(ic), .win_done_o(wd));

    viterbi_channel_err_inj #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .sym_valid_i(vi), .sym_i(sym), .mode_i(mode), .period_i(per),
        .burst_len_i(bl), .thresh_i(th), .bit_mask_i(mask), .win_len_i(win[3:0]), .clr_i(clr),
        .sym_valid_o(vo4), .sym_o(so4), .err_flag_o(err4), .sym_cnt_o(sc4), .inj_cnt_o(ic4), .win_done_o(wd4));

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Model: n = valid symbols since clear, last = index of latest trigger
    logic       e_vo, e_err, e_wd, inj, trig;
    logic [1:0] e_sym;
    logic [15:0] lf;
    int         e_sc, e_ic, n, last, p, b;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_vo = 0; e_sym = 0; e_err = 0; e_sc = 0; e_ic = 0; e_wd = 0;
            n = 0; last = -1; lf = 16'hACE1;
        end else begin
            e_vo = vi; e_sym = sym; e_err = 0;
            if (clr) begin
                e_sc = 0; e_ic = 0; e_wd = 0; n = 0; last = -1; lf = 16'hACE1;
            end else if (vi) begin
                p = int'(per);
                trig = (p != 0) && ((n % p) == p - 1);
                if (trig) last = n;
                b = (bl == 0) ? 1 : int'(bl);
                case (mode)
                    2'b00: inj = 1'b0;
                    2'b01: inj = trig;
                    2'b10: inj = BURST ? (last >= 0 && n - last < b) : trig;
                    default: inj = lf[7:0] < th;
                endcase
                e_sym = sym ^ (inj ? mask : 2'b00);
                e_err = inj;
                if (!e_wd) begin
                    e_sc = (e_sc < 65535) ? e_sc + 1 : e_sc;
                    e_ic = (inj && e_ic < 65535) ? e_ic + 1 : e_ic;
                    e_wd = (win != 0) && (e_sc == int'(win));
                end
                n++;
                lf = lstep(lf);
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("sym_valid", vo, e_vo);
            chk("sym", so, e_sym);
            chk("err_flag", err, e_err);
            chk("sym_cnt", sc, e_sc);
            chk("inj_cnt", ic, e_ic);
            chk("win_done", wd, e_wd);
        end
    end

    // One clear cycle with the new configuration, then nv valid symbols
    task automatic seg(input logic [1:0] m, input logic [7:0] pp, input logic [3:0] l, input logic [7:0] t,
                       input logic [1:0] k, input logic [15:0] w, input int nv, input int vp);
        int done = 0, cyc = 0;
        mode = m; per = pp; bl = l; th = t; mask = k; win = w;
        clr = 1'b1; vi = 1'b1; sym = 2'($urandom);
        @(negedge clk);
        clr = 1'b0;
        while (done < nv && cyc < nv * 20) begin
            vi = ($urandom_range(99) < vp);
            sym = 2'($urandom);
            if (vi) done++;
            cyc++;
            @(negedge clk);
        end
        vi = 1'b0;
        if (done < nv) chk("seg_budget", done, nv);
    endtask

    initial begin
        #1;
        chk("rst_valid", vo, 0); chk("rst_sym", so, 0); chk("rst_err", err, 0);
        chk("rst_sc", sc, 0); chk("rst_ic", ic, 0); chk("rst_wd", wd, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seg(2'b01, 8'd8, 4'd0, 8'd0, 2'b10, 16'd256, 256, 100);
        chk("per_inj", ic, 32); chk("per_sc", sc, 256); chk("per_wd", wd, 1); chk("per_last_err", err, 1);
        seg(2'b10, 8'd16, 4'd3, 8'd0, 2'b11, 16'd0, 64, 100);
        chk("burst_inj", ic, BURST ? 10 : 4);
        seg(2'b11, 8'd5, 4'd0, 8'd0, 2'b11, 16'd0, 200, 80);
        chk("thr0_inj", ic, 0);
        seg(2'b11, 8'd5, 4'd0, 8'hFF, 2'b01, 16'd0, 256, 100);
        chk("thrff_inj_high", ic >= 248, 1);
        seg(2'b01, 8'd0, 4'd0, 8'd0, 2'b11, 16'd0, 200, 100);
        chk("per0_inj", ic, 0);
        seg(2'b01, 8'd4, 4'd0, 8'd0, 2'b11, 16'd0, 3, 100);
        vi = 1'b1; sym = 2'b01; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0; vi = 1'b0;
        chk("clr_sym", so, 1); chk("clr_err", err, 0); chk("clr_sc", sc, 0); chk("clr_ic", ic, 0);
        seg(2'b01, 8'd1, 4'd0, 8'd0, 2'b01, 16'd0, 20, 100);
        chk("sat_sc4", sc4, 15); chk("sat_ic4", ic4, 15); chk("sat_wd4", wd4, 0); chk("sat_ic", ic, 20);
        seg(2'b01, 8'd3, 4'd0, 8'd0, 2'b01, 16'd0, 5, 100);
        vi = 1'b1; sym = 2'b00;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", vo, 0); chk("mid_rst_sym", so, 0); chk("mid_rst_err", err, 0);
        chk("mid_rst_sc", sc, 0); chk("mid_rst_ic", ic, 0); chk("mid_rst_wd", wd, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_p1_err", err, 0);
        @(negedge clk);
        chk("post_rst_p2_err", err, 1); chk("post_rst_sym", so, 1); chk("post_rst_ic", ic, 1); chk("post_rst_sc", sc, 3);
        vi = 1'b0;
        repeat (10)
            seg(2'($urandom), 8'($urandom_range(12)), 4'($urandom_range(5)), 8'($urandom),
                2'($urandom), 16'($urandom_range(60)), 60, 70);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
